// File: rtl/axis_sum_join_ctrl_if.sv
// Lane-side and adder-side handshake bundle for the summing join controller.
// Only valid/ready/last travel here; the sample data bypasses this block.
interface axis_sum_join_ctrl_if #(
    parameter int L = 8
);
    logic [L-1:0] s_tvalid;
    logic [L-1:0] s_tlast;
    logic [L-1:0] s_tready;
    logic         sum_tvalid;
    logic         sum_tready;
    logic         sum_tlast;

    modport slave (
        input  s_tvalid, s_tlast, sum_tready,
        output s_tready, sum_tvalid, sum_tlast
    );

    modport master (
        output s_tvalid, s_tlast, sum_tready,
        input  s_tready, sum_tvalid, sum_tlast
    );
endinterface

// File: rtl/axis_sum_join_ctrl.sv
// Joins the 2*CHANNELS input lanes into one lockstep transfer, frame-aligns them on
// tlast, and recovers from lane skew and partial-valid timeouts.
//
// Handshake rules: a beat moves on a lane when its valid and ready are both high at
// the rising edge. In RUN every lane moves together, s_tready depends on s_tvalid,
// and sum_tvalid never depends on sum_tready.
module axis_sum_join_ctrl #(
    parameter int CHANNELS  = 4,
    parameter int FRAME_LEN = 256,
    parameter int TIMEOUT   = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    axis_sum_join_ctrl_if.slave bus,
    output logic [1:0]          state,
    output logic [15:0]         frame_count,
    output logic [15:0]         err_count,
    output logic [1:0]          err_flags
);
    localparam int L  = 2 * CHANNELS;
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [L-1:0]  aligned_q, aligned_d;
    logic          stop_q, stop_d;
    logic [15:0]   frame_q, frame_d;
    logic [15:0]   err_q, err_d;
    logic [1:0]    flags_q, flags_d;

    logic          all_v, part_v, xfer, beat_last, skew, stop_n;
    logic [L-1:0]  aligned_n;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        tmo_d     = tmo_q;
        aligned_d = aligned_q;
        stop_d    = stop_q;
        frame_d   = frame_q;
        err_d     = err_q;
        flags_d   = flags_q;

        all_v     = &bus.s_tvalid;
        part_v    = (|bus.s_tvalid) & ~all_v;
        beat_last = (beat_q == BW'(FRAME_LEN - 1));
        xfer      = 1'b0;
        skew      = 1'b0;
        stop_n    = stop_q | ~enable;
        aligned_n = aligned_q | (~aligned_q & bus.s_tvalid & bus.s_tlast);

        bus.s_tready   = '0;
        bus.sum_tvalid = 1'b0;
        bus.sum_tlast  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_ALIGN;
                    aligned_d = '0;
                end
            end
            ST_ALIGN: begin
                bus.s_tready = ~aligned_q;
                aligned_d    = aligned_n;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (&aligned_n) begin
                    state_d = ST_RUN;
                    beat_d  = '0;
                    tmo_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            ST_RUN: begin
                xfer           = all_v & bus.sum_tready;
                skew           = xfer & (bus.s_tlast != {L{beat_last}});
                bus.sum_tvalid = all_v;
                bus.sum_tlast  = beat_last;
                bus.s_tready   = {L{xfer}};
                tmo_d          = part_v ? tmo_q + TW'(1) : '0;
                stop_d         = stop_n;
                if (xfer) begin
                    beat_d = beat_last ? '0 : beat_q + BW'(1);
                end
                // Skew can only occur on a transfer and timeout never does, so skew has priority.
                if (skew) begin
                    flags_d[0] = 1'b1;
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    aligned_d  = bus.s_tlast;
                    state_d    = stop_n ? ST_IDLE : ST_ALIGN;
                    stop_d     = 1'b0;
                end else if (xfer && beat_last) begin
                    frame_d = frame_q + 16'd1;
                    if (stop_n) begin
                        state_d = ST_IDLE;
                        stop_d  = 1'b0;
                    end
                end else if (part_v && (tmo_q == TW'(TIMEOUT - 1))) begin
                    flags_d[1] = 1'b1;
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    aligned_d  = '0;
                    tmo_d      = '0;
                    stop_d     = 1'b0;
                    state_d    = ST_ALIGN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            tmo_q     <= '0;
            aligned_q <= '0;
            stop_q    <= 1'b0;
            frame_q   <= '0;
            err_q     <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            tmo_q     <= tmo_d;
            aligned_q <= aligned_d;
            stop_q    <= stop_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
            flags_q   <= flags_d;
        end
    end

    assign state       = state_q;
    assign frame_count = frame_q;
    assign err_count   = err_q;
    assign err_flags   = flags_q;
endmodule

// File: tb/tb_axis_sum_join_ctrl.sv
// Bench for axis_sum_join_ctrl: per-lane frame sources, a sum_tlast scoreboard,
// a combinational RUN vector table and hand-written error/stop/reset sequences.
module tb_axis_sum_join_ctrl;
    localparam int CH = 4;
    localparam int L  = 2 * CH;
    localparam int FL = 256;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  state;
    logic [15:0] frame_count;
    logic [15:0] err_count;
    logic [1:0]  err_flags;

    axis_sum_join_ctrl_if #(.L(L)) bus ();

    axis_sum_join_ctrl #(.CHANNELS(CH), .FRAME_LEN(FL), .TIMEOUT(TO)) dut (
        .clock       (clk),
        .reset       (rst),
        .enable      (enable),
        .bus         (bus),
        .state       (state),
        .frame_count (frame_count),
        .err_count   (err_count),
        .err_flags   (err_flags)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [L-1:0] valid;
        logic         rdy;
        logic [L-1:0] exp_tready;
        logic         exp_svalid;
    } vec_t;

    vec_t         tbl[6];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [0:0]   exp_q[$];
    int           lane_idx[L];
    logic [L-1:0] lane_en;
    logic         rdy;
    logic         sb_on;
    int           tlast_seen;
    int           xfer_cnt;
    int           x0;
    logic [L-1:0] last_tready;
    logic         last_svalid;
    logic         last_stlast;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive lane sources at negedge, observe the handshake, advance on posedge.
    task automatic step();
        logic [L-1:0] hs;
        logic         joint;
        logic [0:0]   e;
        @(negedge clk);
        for (int i = 0; i < L; i++) begin
            bus.s_tvalid[i] = lane_en[i];
            bus.s_tlast[i]  = (lane_idx[i] == FL - 1);
        end
        bus.sum_tready = rdy;
        #1;
        hs          = bus.s_tvalid & bus.s_tready;
        joint       = bus.sum_tvalid & bus.sum_tready;
        last_tready = bus.s_tready;
        last_svalid = bus.sum_tvalid;
        last_stlast = bus.sum_tlast;
        if (joint) begin
            xfer_cnt++;
            if (bus.sum_tlast) tlast_seen++;
        end
        if (sb_on && (&lane_en) && rdy) exp_q.push_back(lane_idx[0] == FL - 1);
        if (sb_on) begin
            if (joint) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_xfer", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_sum_tlast", {31'd0, bus.sum_tlast}, {31'd0, e});
                end
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                chk("sb_missing_xfer", 32'd0, 32'd1);
            end
        end
        @(posedge clk);
        for (int i = 0; i < L; i++) begin
            if (hs[i]) lane_idx[i] = (lane_idx[i] + 1) % FL;
        end
        #1;
    endtask

    task automatic wait_state(input logic [1:0] target, input int bound, input string name);
        int n;
        n = 0;
        while (state != target && n < bound) begin
            step();
            n++;
        end
        chk(name, {30'd0, state}, {30'd0, target});
    endtask

    initial begin
        tbl[0] = '{valid: 8'hFF, rdy: 1'b1, exp_tready: 8'hFF, exp_svalid: 1'b1};
        tbl[1] = '{valid: 8'hFF, rdy: 1'b0, exp_tready: 8'h00, exp_svalid: 1'b1};
        tbl[2] = '{valid: 8'hF7, rdy: 1'b1, exp_tready: 8'h00, exp_svalid: 1'b0};
        tbl[3] = '{valid: 8'h00, rdy: 1'b1, exp_tready: 8'h00, exp_svalid: 1'b0};
        tbl[4] = '{valid: 8'h01, rdy: 1'b1, exp_tready: 8'h00, exp_svalid: 1'b0};
        tbl[5] = '{valid: 8'hFE, rdy: 1'b0, exp_tready: 8'h00, exp_svalid: 1'b0};

        rst = 1'b1; enable = 1'b0; lane_en = '0; rdy = 1'b1; sb_on = 1'b0;
        tlast_seen = 0; xfer_cnt = 0;
        for (int i = 0; i < L; i++) lane_idx[i] = 200;
        bus.s_tvalid = '0; bus.s_tlast = '0; bus.sum_tready = 1'b0;

        // Reset state, with lanes offering beats that must not be accepted.
        repeat (3) step();
        lane_en = '1;
        step();
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
        chk("rst_err_count", {16'd0, err_count}, 32'd0);
        chk("rst_err_flags", {30'd0, err_flags}, 32'd0);
        chk("rst_s_tready", {24'd0, last_tready}, 32'd0);
        chk("rst_sum_tvalid", {31'd0, last_svalid}, 32'd0);

        // Enable: ALIGN swallows the tail of the prior frame, then three clean frames.
        rst = 1'b0; enable = 1'b1;
        step();
        chk("idle_to_align", {30'd0, state}, 32'd1);
        wait_state(2'd2, 300, "align_to_run");
        chk("align_consumed_tail", lane_idx[0], 32'd0);
        sb_on = 1'b1; tlast_seen = 0;
        repeat (3 * FL) step();
        chk("frames3_count", {16'd0, frame_count}, 32'd3);
        chk("frames3_err", {16'd0, err_count}, 32'd0);
        chk("frames3_flags", {30'd0, err_flags}, 32'd0);
        chk("frames3_tlast_pulses", tlast_seen, 32'd3);

        // Combinational RUN handshake table at beat 0, all within one low clock phase.
        @(negedge clk);
        for (int v = 0; v < 6; v++) begin
            bus.s_tvalid   = tbl[v].valid;
            bus.s_tlast    = '0;
            bus.sum_tready = tbl[v].rdy;
            #1;
            chk($sformatf("tbl%0d_s_tready", v), {24'd0, bus.s_tready}, {24'd0, tbl[v].exp_tready});
            chk($sformatf("tbl%0d_sum_tvalid", v), {31'd0, bus.sum_tvalid}, {31'd0, tbl[v].exp_svalid});
            chk($sformatf("tbl%0d_sum_tlast", v), {31'd0, bus.sum_tlast}, 32'd0);
        end
        bus.s_tvalid = '0;
        bus.sum_tready = 1'b1;
        @(posedge clk);
        #1;

        // Downstream stall mid-frame: nothing moves, no timeout, frame resumes in place.
        repeat (10) step();
        rdy = 1'b0; x0 = xfer_cnt;
        repeat (100) begin
            step();
            chk("stall_s_tready", {24'd0, last_tready}, 32'd0);
        end
        chk("stall_no_xfer", xfer_cnt - x0, 32'd0);
        chk("stall_state", {30'd0, state}, 32'd2);
        chk("stall_flags", {30'd0, err_flags}, 32'd0);
        rdy = 1'b1;
        repeat (FL - 10) step();
        chk("stall_frame_count", {16'd0, frame_count}, 32'd4);

        // Lane 3 repeats a beat at 100, so its tlast lags the joint frame end.
        repeat (100) step();
        lane_idx[3] = lane_idx[3] - 1;
        repeat (156) step();
        sb_on = 1'b0;
        chk("skew_state", {30'd0, state}, 32'd1);
        chk("skew_flags", {30'd0, err_flags}, 32'd1);
        chk("skew_err_count", {16'd0, err_count}, 32'd1);
        chk("skew_frame_count", {16'd0, frame_count}, 32'd4);
        wait_state(2'd2, 10, "skew_realign");
        chk("skew_lane3_idx", lane_idx[3], 32'd0);
        chk("skew_lane0_idx", lane_idx[0], 32'd0);
        sb_on = 1'b1;
        repeat (FL) step();
        chk("skew_recover_frames", {16'd0, frame_count}, 32'd5);

        // Lane 5 withholds valid: timeout on exactly the TO-th partial cycle.
        sb_on = 1'b0; lane_en[5] = 1'b0; x0 = xfer_cnt;
        repeat (TO - 1) step();
        chk("timeout_not_early", {30'd0, state}, 32'd2);
        step();
        chk("timeout_state", {30'd0, state}, 32'd1);
        chk("timeout_flags", {30'd0, err_flags}, 32'd3);
        chk("timeout_err_count", {16'd0, err_count}, 32'd2);
        chk("timeout_no_xfer", xfer_cnt - x0, 32'd0);
        lane_en = '1;
        wait_state(2'd2, 600, "timeout_realign");

        // Enable dropped at beat 10: frame completes, then IDLE.
        sb_on = 1'b1;
        repeat (10) step();
        enable = 1'b0;
        repeat (FL - 11) step();
        chk("stop_still_run", {30'd0, state}, 32'd2);
        step();
        chk("stop_idle", {30'd0, state}, 32'd0);
        chk("stop_frame_count", {16'd0, frame_count}, 32'd6);
        sb_on = 1'b0;
        repeat (3) step();
        chk("stop_s_tready", {24'd0, last_tready}, 32'd0);
        chk("stop_sum_tvalid", {31'd0, last_svalid}, 32'd0);
        chk("stop_frame_hold", {16'd0, frame_count}, 32'd6);

        // Reset at beat 128, then a fresh run must start its beat counter at 0.
        enable = 1'b1;
        wait_state(2'd2, 600, "rerun_align");
        sb_on = 1'b1;
        repeat (128) step();
        sb_on = 1'b0; rst = 1'b1;
        step();
        chk("midrst_state", {30'd0, state}, 32'd0);
        chk("midrst_frame_count", {16'd0, frame_count}, 32'd0);
        chk("midrst_err_count", {16'd0, err_count}, 32'd0);
        chk("midrst_err_flags", {30'd0, err_flags}, 32'd0);
        rst = 1'b0; enable = 1'b0;
        step();
        chk("midrst_s_tready", {24'd0, last_tready}, 32'd0);
        chk("midrst_sum_tvalid", {31'd0, last_svalid}, 32'd0);
        chk("midrst_sum_tlast", {31'd0, last_stlast}, 32'd0);
        enable = 1'b1;
        wait_state(2'd2, 600, "postrst_align");
        sb_on = 1'b1;
        repeat (FL) step();
        chk("postrst_frame_count", {16'd0, frame_count}, 32'd1);
        chk("postrst_err_count", {16'd0, err_count}, 32'd0);
        chk("sb_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
